// File: rtl/keypad_entry.sv
// Keypad entry: synchronizes and debounces a held key code, then edits a
// four-digit entry buffer with backspace and enter.
module keypad_entry #(
    parameter int unsigned SAMPLE_TICKS   = 100000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        overflow
);

    localparam int unsigned PW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [PW-1:0] PreLast = PW'(SAMPLE_TICKS - 1);
    localparam logic [SW-1:0] StabMax = SW'(STABLE_SAMPLES);
    localparam logic [SW-1:0] StabPre = SW'(STABLE_SAMPLES - 1);

    typedef enum logic [1:0] {StEmpty, StEntering, StFull} state_e;

    logic [3:0]    key_s1_q, key_s2_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    cand_q, cand_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [3:0]    stable_q, stable_d;
    logic          armed_q, armed_d;
    state_e        state_q, state_d;
    logic          key_event_q, key_event_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [15:0]   entry_q, entry_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   value_q, value_d;
    logic          vv_q, vv_d;
    logic          ovf_q, ovf_d;
    logic          strobe, accept, new_event;

    always_comb begin
        strobe = (pre_q == PreLast);
        pre_d  = strobe ? '0 : pre_q + 1'b1;
        cand_d = cand_q;
        stab_d = stab_q;
        accept = 1'b0;
        if (strobe) begin
            if (key_s2_q == cand_q) begin
                // Accept only on the strobe that first reaches the threshold.
                if (stab_q != StabMax) begin
                    stab_d = stab_q + 1'b1;
                    accept = (stab_q == StabPre);
                end
            end else begin
                cand_d = key_s2_q;
                stab_d = SW'(1);
            end
        end

        stable_d  = stable_q;
        armed_d   = armed_q;
        new_event = 1'b0;
        if (accept) begin
            stable_d  = cand_q;
            armed_d   = 1'b1;
            new_event = armed_q && (cand_q != stable_q);
        end
        key_event_d = new_event;
        key_code_d  = new_event ? cand_q : key_code_q;

        // Entry edits commit on the same edge as key_event so they appear together.
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        vv_d    = 1'b0;
        ovf_d   = 1'b0;
        if (new_event) begin
            if (cand_q <= 4'hD) begin
                if (state_q == StFull) begin
                    ovf_d = 1'b1;
                end else begin
                    entry_d = {entry_q[11:0], cand_q};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd3) ? StFull : StEntering;
                end
            end else if (cand_q == 4'hE) begin
                if (state_q != StEmpty) begin
                    entry_d = {4'h0, entry_q[15:4]};
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? StEmpty : StEntering;
                end
            end else if (state_q != StEmpty) begin
                value_d = entry_q;
                vv_d    = 1'b1;
                entry_d = '0;
                cnt_d   = '0;
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            pre_q       <= '0;
            cand_q      <= '0;
            stab_q      <= '0;
            stable_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= StEmpty;
            key_event_q <= 1'b0;
            key_code_q  <= '0;
            entry_q     <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            vv_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            key_s1_q    <= key;
            key_s2_q    <= key_s1_q;
            pre_q       <= pre_d;
            cand_q      <= cand_d;
            stab_q      <= stab_d;
            stable_q    <= stable_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            vv_q        <= vv_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_event   = key_event_q;
    assign key_code    = key_code_q;
    assign entry       = entry_q;
    assign digit_cnt   = cnt_q;
    assign value       = value_q;
    assign value_valid = vv_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus queues the expected key_event
// snapshot, a negedge monitor pops and compares it when key_event fires.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        key_event;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [15:0] value;
    logic        value_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] value;
        logic        vv;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    keypad_entry #(
        .SAMPLE_TICKS  (4),
        .STABLE_SAMPLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_event  (key_event),
        .key_code   (key_code),
        .entry      (entry),
        .digit_cnt  (digit_cnt),
        .value      (value),
        .value_valid(value_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_key_event"}, {15'd0, key_event}, 16'h0);
        chk({tag, "_key_code"}, {12'd0, key_code}, 16'h0);
        chk({tag, "_entry"}, entry, 16'h0);
        chk({tag, "_digit_cnt"}, {13'd0, digit_cnt}, 16'h0);
        chk({tag, "_value"}, value, 16'h0);
        chk({tag, "_pulses"}, {14'd0, value_valid, overflow}, 16'h0);
    endtask

    task automatic hold(input logic [3:0] k, input int cycles);
        key = k;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Queue the expected snapshot, then present the key long enough to qualify.
    task automatic press(input logic [3:0] k, input logic [15:0] e_entry, input logic [2:0] e_cnt,
                         input logic [15:0] e_value, input logic e_vv, input logic e_ov);
        exp_t e;
        e.code  = k;
        e.entry = e_entry;
        e.cnt   = e_cnt;
        e.value = e_value;
        e.vv    = e_vv;
        e.ov    = e_ov;
        sb.push_back(e);
        hold(k, 24);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (key_event) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %h entry %h expected no event",
                             key_code, entry);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ev_key_code", {12'd0, key_code}, {12'd0, e.code});
                    chk("ev_entry", entry, e.entry);
                    chk("ev_digit_cnt", {13'd0, digit_cnt}, {13'd0, e.cnt});
                    chk("ev_value", value, e.value);
                    chk("ev_value_valid", {15'd0, value_valid}, {15'd0, e.vv});
                    chk("ev_overflow", {15'd0, overflow}, {15'd0, e.ov});
                end
            end else begin
                chk("pulse_outside_event", {14'd0, value_valid, overflow}, 16'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        key = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Scenario 1: first stable value only arms.
        hold(4'h5, 20);
        press(4'h1, 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0);

        // Scenario 2: fill to four digits, fifth overflows.
        press(4'h2, 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0);
        press(4'h3, 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0);
        press(4'h4, 16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0);
        press(4'h5, 16'h1234, 3'd4, 16'h0000, 1'b0, 1'b1);

        // Scenario 3: backspace then enter.
        press(4'hE, 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0);
        press(4'hF, 16'h0000, 3'd0, 16'h0123, 1'b1, 1'b0);

        // Scenario 4: two-sample glitch never qualifies; returning to F is not a change.
        hold(4'h7, 8);
        hold(4'hF, 24);
        chk("glitch_entry", entry, 16'h0000);
        chk("glitch_digit_cnt", {13'd0, digit_cnt}, 16'h0);
        chk("glitch_value", value, 16'h0123);
        chk("glitch_key_code", {12'd0, key_code}, 16'h000F);

        // Scenario 5: backspace and enter ignored while empty, but still events.
        press(4'hE, 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0);
        press(4'hF, 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0);

        // Scenario 6: asynchronous reset mid-entry.
        press(4'h1, 16'h0001, 3'd1, 16'h0123, 1'b0, 1'b0);
        press(4'h2, 16'h0012, 3'd2, 16'h0123, 1'b0, 1'b0);
        chk("pre_reset_entry", entry, 16'h0012);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(4'h9, 24);
        chk("rearm_entry", entry, 16'h0000);
        press(4'h3, 16'h0003, 3'd1, 16'h0000, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
